mul_div_unit: RTL and testbench

Iterative multiply/divide unit in the MIPS EX stage, beside the 32-bit ALU. It consumes the same A/B operand bus the ALU does and executes MULT, MULTU, DIV and DIVU over multiple cycles. Results go into architectural HI/LO registers. `busy` drives the pipeline stall logic until the result is committed.

---
 rtl/mul_div_pkg.sv | 20 ++
 rtl/mul_div_step.sv | 59 +++++
 rtl/mul_div_unit.sv | 187 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state type and the default datapath width.
package mul_div_pkg;

  localparam int MD_WIDTH_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_RUN,
    ST_FIX,
    ST_DONE
  } md_state_t;

endpackage

// File: rtl/mul_div_step.sv
// Single-iteration datapath of the multiply/divide unit (purely combinational).
// The accumulator is {hi, lo}. Multiply: lo holds the remaining multiplier
// bits and hi the partial product (shift-add, LSB first). Divide: lo holds the
// remaining dividend bits / growing quotient and hi the partial remainder
// (restoring shift-subtract, MSB first).
// Optional macro: MUL_DIV_DIVIDE_EN compiles the divide step in; without it a
// divide-mode request simply holds the accumulator.
module mul_div_step
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               mode,      // 0: multiply step, 1: divide step
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  // Shift-add: conditionally add the multiplicand, then shift the pair right
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

`ifdef MUL_DIV_DIVIDE_EN
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH-1:0]     rem_diff;
  logic                 rem_ge;
  logic [2*WIDTH-1:0]   div_next;

  // Restoring divide: shift next dividend bit in, subtract divisor if it fits.
  // The partial remainder is always below the divisor, so when the subtraction
  // succeeds the difference fits in WIDTH bits.
  always_comb begin
    rem_shift = acc[2*WIDTH-1:WIDTH-1];
    rem_ge    = (rem_shift >= {1'b0, operand});
    rem_diff  = rem_shift[WIDTH-1:0] - operand;
    if (rem_ge) begin
      div_next = {rem_diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Select the step result for the current operation
  always_comb begin
    acc_next = mode ? div_next : mul_next;
  end
`else
  // Divide hardware absent: divide mode never reaches RUN, hold if it did
  always_comb begin
    acc_next = mode ? acc : mul_next;
  end
`endif

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Signed operations run on magnitudes; the sign is restored in the FIX cycle.
// Optional macro: MUL_DIV_DIVIDE_EN enables DIV/DIVU. Without it divide
// requests are ignored and DivZeroFlag is tied low.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivZeroFlag
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_t          state_reg, state_next;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, opnd_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;
  logic [2*WIDTH-1:0] acc_reg, step_acc, product;
  logic [CW-1:0]      count_reg;
  logic               q_neg_reg;

  logic               op_ok, div_zero, signed_op;
  logic               a_sign, b_sign;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

`ifdef MUL_DIV_DIVIDE_EN
  logic               r_neg_reg;
  logic               flag_reg;

  assign op_ok    = 1'b1;
  assign div_zero = op_reg[1] && (b_reg == '0);
  assign DivZeroFlag = flag_reg;
`else
  assign op_ok    = ~op[1];
  assign div_zero = 1'b0;
  assign DivZeroFlag = 1'b0;
`endif

  // MULT and DIV (op[0]=0) are the signed variants
  assign signed_op = ~op_reg[0];
  assign a_sign    = signed_op & a_reg[WIDTH-1];
  assign b_sign    = signed_op & b_reg[WIDTH-1];
  assign a_abs     = a_sign ? -a_reg : a_reg;
  assign b_abs     = b_sign ? -b_reg : b_reg;

  mul_div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_reg),
    .operand  (opnd_reg),
    .mode     (op_reg[1]),
    .acc_next (step_acc)
  );

  // Sign correction of the raw magnitude result
  always_comb begin
    product = q_neg_reg ? -acc_reg : acc_reg;
    fix_hi  = product[2*WIDTH-1:WIDTH];
    fix_lo  = product[WIDTH-1:0];
`ifdef MUL_DIV_DIVIDE_EN
    if (op_reg[1]) begin
      fix_hi = r_neg_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
      fix_lo = q_neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    end
`endif
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort always wins over start and over progress
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (start && !abort && op_ok) begin
          state_next = ST_PREP;
        end
      end
      ST_PREP: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (div_zero) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (count_reg == CW'(WIDTH - 1)) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        state_next = abort ? ST_IDLE : ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register only
  always_comb begin
    busy = (state_reg == ST_PREP) || (state_reg == ST_RUN) || (state_reg == ST_FIX);
    done = (state_reg == ST_DONE);
  end

  assign HI = hi_reg;
  assign LO = lo_reg;

  // Operand latch, iteration datapath and HI/LO commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      opnd_reg  <= '0;
      acc_reg   <= '0;
      count_reg <= '0;
      q_neg_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
`ifdef MUL_DIV_DIVIDE_EN
      r_neg_reg <= 1'b0;
      flag_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (state_next == ST_PREP) begin
            a_reg  <= A;
            b_reg  <= B;
            op_reg <= op;
          end
        end
        ST_PREP: begin
          acc_reg   <= {{WIDTH{1'b0}}, a_abs};
          opnd_reg  <= b_abs;
          q_neg_reg <= a_sign ^ b_sign;
          count_reg <= '0;
`ifdef MUL_DIV_DIVIDE_EN
          r_neg_reg <= a_sign;
          if (!abort && div_zero) begin
            hi_reg   <= a_reg;
            lo_reg   <= '1;
            flag_reg <= 1'b1;
          end
`endif
        end
        ST_RUN: begin
          acc_reg   <= step_acc;
          count_reg <= count_reg + 1'b1;
        end
        ST_FIX: begin
          if (!abort) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
`ifdef MUL_DIV_DIVIDE_EN
            flag_reg <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32). Expected results come from
// plain 64-bit integer arithmetic; divide checks follow MUL_DIV_DIVIDE_EN.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        abort;
  logic        busy, done;
  logic [31:0] HI, LO;
  logic        DivZeroFlag;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_hi, model_lo;
  logic        model_flag;

`ifdef MUL_DIV_DIVIDE_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .A           (A),
    .B           (B),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .HI          (HI),
    .LO          (LO),
    .DivZeroFlag (DivZeroFlag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result of one operation, from integer arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic ef, output int lat, output bit ign);
    longint          sp, sa, sb, q, r;
    longint unsigned up;
    ign = 1'b0; lat = 35; ef = 1'b0; eh = '0; el = '0;
    case (o)
      2'b00: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        eh = sp[63:32]; el = sp[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        eh = up[63:32]; el = up[31:0];
      end
      default: begin
        if (!DIV_EN) begin
          ign = 1'b1;
        end else if (b == 32'd0) begin
          eh = a; el = 32'hFFFF_FFFF; ef = 1'b1; lat = 2;
        end else if (o == 2'b10) begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = a / b; eh = a % b;
        end
      end
    endcase
  endfunction

  // Issue one operation and check busy/done timing and the committed result
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic        ef;
    int          lat;
    bit          ign;
    model(o, a, b, eh, el, ef, lat, ign);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); A = $urandom; B = $urandom;
    if (ign) begin
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        chk("ign_busy", busy, 0);
        chk("ign_done", done, 0);
      end
      chk("ign_hi", HI, model_hi);
      chk("ign_lo", LO, model_lo);
      $display("txn op=%0d A=%h B=%h ignored HI=%h LO=%h", o, a, b, HI, LO);
    end else begin
      for (int c = 1; c <= lat; c++) begin
        @(negedge clk);
        if (c < lat) begin
          chk("busy_run", busy, 1);
          chk("done_early", done, 0);
        end else begin
          chk("busy_done", busy, 0);
          chk("done_cycle", done, 1);
          chk("hi", HI, eh);
          chk("lo", LO, el);
          chk("flag", DivZeroFlag, ef);
        end
      end
      model_hi = eh; model_lo = el; model_flag = ef;
      $display("txn op=%0d A=%h B=%h -> HI=%h LO=%h flag=%0b", o, a, b, HI, LO, DivZeroFlag);
    end
  endtask

  initial begin
    int first, second;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; A = '0; B = '0;
    model_hi = '0; model_lo = '0; model_flag = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_flag", DivZeroFlag, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Directed operations
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'b11, 32'd100, 32'd0);
    run_op(2'b01, 32'd2, 32'd3);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
      run_op(2'($urandom_range(0, 3)), ra, rb);
    end

    // start together with abort in IDLE is dropped
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 2'b01; A = 32'd3; B = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("abort_start_busy", busy, 0);
      chk("abort_start_done", done, 0);
    end

    // Abort during RUN leaves HI/LO from the previous commit
    run_op(2'b01, 32'd7, 32'd9);
    @(negedge clk);
    start = 1'b1; op = 2'b01; A = 32'd2; B = 32'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 10) begin
        chk("abort_busy_before", busy, 1);
        abort = 1'b1;
      end
      if (c == 11) begin
        abort = 1'b0;
        chk("abort_busy_after", busy, 0);
      end
      chk("abort_no_done", done, 0);
    end
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd63);
    $display("txn abort MULTU 2x2 HI=%h LO=%h", HI, LO);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    start = 1'b1; op = 2'b01; A = $urandom; B = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", HI, 0);
    chk("midrst_lo", LO, 0);
    chk("midrst_flag", DivZeroFlag, 0);
    model_hi = '0; model_lo = '0; model_flag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset mid-run HI=%h LO=%h", HI, LO);

    // Back-to-back: new start held during DONE
    @(negedge clk);
    start = 1'b1; op = 2'b01; A = 32'd2; B = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        first = c;
        break;
      end
    end
    chk("b2b_first_cycle", 64'(first), 64'd35);
    chk("b2b_first_lo", LO, 32'd6);
    start = 1'b1; op = 2'b01; A = 32'd4; B = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    second = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) chk("b2b_busy", busy, 1);
      if (done) begin
        second = c;
        break;
      end
    end
    chk("b2b_second_cycle", 64'(second), 64'd35);
    chk("b2b_second_lo", LO, 32'd20);
    chk("b2b_second_hi", HI, 32'd0);
    $display("txn back-to-back first=%0d second=%0d LO=%h", first, second, LO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
